// File: rtl/edge_pkg.sv
// Shared defaults, state encoding and slot index type for the window fetch path.
package edge_pkg;

    localparam int unsigned PIXEL_W_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned WIN_SLOTS   = 9;

    typedef logic [3:0] slot_idx_t;

    typedef enum logic [2:0] {
        StIdle,
        StReqAddr,
        StWaitAddr,
        StMemRead,
        StWaitData,
        StWinOut,
        StDone
    } fetch_state_t;

endpackage

// File: rtl/window_pack_reg.sv
// Nine pixel registers packed into one window word; slot 0 sits in the low bits.
module window_pack_reg
    import edge_pkg::*;
#(
    parameter int unsigned PIXEL_W = PIXEL_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  slot_idx_t                    wr_slot,
    input  logic [PIXEL_W-1:0]           wr_data,
    output logic [WIN_SLOTS*PIXEL_W-1:0] window
);

    always_ff @(posedge clk) begin
        if (rst) begin
            window <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < WIN_SLOTS; k++) begin
                if (wr_slot == slot_idx_t'(k)) begin
                    window[k*PIXEL_W +: PIXEL_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/window_fetch.sv
// Fetches nine pixels per window via the address counter and pixel memory, then
// presents the packed 3x3 window to the gradient filter with a valid/accept handshake.
module window_fetch
    import edge_pkg::*;
#(
    parameter int unsigned PIXEL_W = PIXEL_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [CNT_W-1:0]             i_num_windows,
    input  logic [ADDR_W-1:0]            i_raddr,
    input  logic                         i_r_ready,
    output logic                         o_inc_raddr,
    output logic                         o_mem_ren,
    output logic [ADDR_W-1:0]            o_mem_addr,
    input  logic [PIXEL_W-1:0]           i_mem_rdata,
    input  logic                         i_mem_rvalid,
    output logic [WIN_SLOTS*PIXEL_W-1:0] o_window,
    output logic                         o_win_valid,
    input  logic                         i_win_accept,
    output logic                         o_busy,
    output logic                         o_frame_done
);

    fetch_state_t      state_q, state_d;
    slot_idx_t         slot_q, slot_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [ADDR_W-1:0] addr_d;
    logic              pix_we;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        count_d = count_q;
        num_d   = num_q;
        addr_d  = o_mem_addr;
        pix_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    num_d   = i_num_windows;
                    count_d = '0;
                    slot_d  = '0;
                    if (i_num_windows == '0) begin
                        state_d = StDone;
                    end else begin
                        // Counter already holds the initial address, so no increment first.
                        addr_d  = i_raddr;
                        state_d = StMemRead;
                    end
                end
            end
            StReqAddr:  state_d = StWaitAddr;
            StWaitAddr: begin
                if (i_r_ready) begin
                    addr_d  = i_raddr;
                    state_d = StMemRead;
                end
            end
            StMemRead:  state_d = StWaitData;
            StWaitData: begin
                if (i_mem_rvalid) begin
                    pix_we = 1'b1;
                    if (slot_q == slot_idx_t'(WIN_SLOTS - 1)) begin
                        state_d = StWinOut;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = StReqAddr;
                    end
                end
            end
            StWinOut: begin
                if (i_win_accept) begin
                    count_d = count_q + 1'b1;
                    slot_d  = '0;
                    state_d = (count_d == num_q) ? StDone : StReqAddr;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            count_q      <= '0;
            num_q        <= '0;
            o_mem_addr   <= '0;
            o_inc_raddr  <= 1'b0;
            o_mem_ren    <= 1'b0;
            o_win_valid  <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            count_q      <= count_d;
            num_q        <= num_d;
            o_mem_addr   <= addr_d;
            o_inc_raddr  <= (state_d == StReqAddr);
            o_mem_ren    <= (state_d == StMemRead);
            o_win_valid  <= (state_d == StWinOut);
            o_busy       <= (state_d != StIdle);
            o_frame_done <= (state_d == StDone);
        end
    end

    window_pack_reg #(
        .PIXEL_W (PIXEL_W)
    ) u_pack (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pix_we),
        .wr_slot (slot_q),
        .wr_data (i_mem_rdata),
        .window  (o_window)
    );

endmodule

// File: tb/tb_window_fetch.sv
// Randomized scoreboard bench for window_fetch: the bench plays address counter,
// pixel memory and filter, and checks fetched addresses and windows against a queue model.
module tb_window_fetch;

    localparam int PW = 8;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int WW = 9 * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [CW-1:0] i_num_windows;
    logic [AW-1:0] i_raddr;
    logic          i_r_ready;
    logic          o_inc_raddr;
    logic          o_mem_ren;
    logic [AW-1:0] o_mem_addr;
    logic [PW-1:0] i_mem_rdata;
    logic          i_mem_rvalid;
    logic [WW-1:0] o_window;
    logic          o_win_valid;
    logic          i_win_accept;
    logic          o_busy;
    logic          o_frame_done;

    always #5 clk = ~clk;

    window_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_num_windows (i_num_windows),
        .i_raddr       (i_raddr),
        .i_r_ready     (i_r_ready),
        .o_inc_raddr   (o_inc_raddr),
        .o_mem_ren     (o_mem_ren),
        .o_mem_addr    (o_mem_addr),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_rvalid  (i_mem_rvalid),
        .o_window      (o_window),
        .o_win_valid   (o_win_valid),
        .i_win_accept  (i_win_accept),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done)
    );

    // Reference model state: address sequence served by the counter, memory contents,
    // and the expected reads / windows in order.
    logic [AW-1:0] seq[$];
    int            seq_idx = 0;
    logic [PW-1:0] mem[logic [AW-1:0]];
    logic [AW-1:0] exp_addr[$];
    logic [WW-1:0] exp_win[$];

    int compared = 0, mismatched = 0;
    int ren_cnt = 0, inc_cnt = 0, done_cnt = 0, hs_cnt = 0;
    int cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    logic [AW-1:0] first_addr = '0;
    logic [WW-1:0] last_win = '0;
    int bp_hold = 0, force_lat = 0;
    bit acc_always = 1'b0, spur_en = 1'b1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reads memory or hands over a window.
    initial begin : monitor
        logic [AW-1:0] ea;
        logic [WW-1:0] ew;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (o_mem_ren) begin
                    ren_cnt++;
                    if (ren_cnt == 1) first_addr = o_mem_addr;
                    if (exp_addr.size() > 0) ea = exp_addr.pop_front();
                    else ea = 'x;
                    check("mem_addr", o_mem_addr, ea);
                end
                if (o_inc_raddr) inc_cnt++;
                if (o_frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (o_win_valid && i_win_accept) begin
                    hs_cnt++;
                    last_hs_cyc = cyc;
                    last_win    = o_window;
                    if (exp_win.size() > 0) ew = exp_win.pop_front();
                    else ew = 'x;
                    check("window", o_window, ew);
                end
            end
        end
    end

    // Address counter and pixel memory with random latency and spurious strobes.
    initial begin : env
        int mem_cd, adr_cd;
        logic [AW-1:0] ma;
        mem_cd = 0; adr_cd = 0; ma = '0;
        i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_r_ready = 1'b0; i_raddr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_mem_ren) begin
                    mem_cd = (force_lat > 0) ? force_lat : int'($urandom_range(1, 3));
                    ma     = o_mem_addr;
                end
                if (o_inc_raddr) adr_cd = int'($urandom_range(1, 3));
            end
            @(posedge clk);
            #1;
            i_mem_rvalid = 1'b0;
            i_r_ready    = 1'b0;
            if (mem_cd > 0) begin
                mem_cd--;
                if (mem_cd == 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = mem.exists(ma) ? mem[ma] : '0;
                end else if (spur_en) begin
                    i_r_ready = 1'b1;
                end
            end
            if (adr_cd > 0) begin
                adr_cd--;
                if (adr_cd == 0) begin
                    if (seq_idx + 1 < seq.size()) seq_idx++;
                    i_r_ready = 1'b1;
                end else if (spur_en) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = 8'hEE;
                end
            end
            if (seq_idx < seq.size()) i_raddr = seq[seq_idx];
        end
    end

    initial begin : acceptor
        i_win_accept = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_win_valid && bp_hold > 0) begin
                bp_hold--;
                i_win_accept = 1'b0;
            end else begin
                i_win_accept = o_win_valid && (acc_always || $urandom_range(0, 2) == 0);
            end
        end
    end

    task automatic build(input int n, input bit directed);
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        seq.delete(); exp_addr.delete(); exp_win.delete(); mem.delete();
        seq_idx = 0;
        if (directed) begin
            seq = {32'h100, 32'h101, 32'h102, 32'h1A8, 32'h1A9, 32'h1AA,
                   32'h250, 32'h251, 32'h252, 32'h253};
            for (int k = 0; k < 9; k++) mem[seq[k]] = 8'(32'h10 + k);
        end else begin
            a = AW'($urandom_range(0, 32'hFFFF));
            seq.push_back(a);
            for (int k = 0; k < 9 * n; k++) begin
                a = a + AW'($urandom_range(1, 64));
                seq.push_back(a);
            end
            for (int k = 0; k < 9 * n; k++) mem[seq[k]] = 8'($urandom);
        end
        for (int wi = 0; wi < n; wi++) begin
            for (int k = 0; k < 9; k++) begin
                w[k*PW +: PW] = mem[seq[9*wi + k]];
                exp_addr.push_back(seq[9*wi + k]);
            end
            exp_win.push_back(w);
        end
    endtask

    task automatic start_frame(input int n);
        ren_cnt = 0; inc_cnt = 0; done_cnt = 0; hs_cnt = 0;
        @(posedge clk);
        #2;
        i_start       = 1'b1;
        i_num_windows = CW'(n);
        @(posedge clk);
        #2;
        i_start = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit directed, input bit start_busy, input int hold);
        int t, viol, start_cyc;
        logic [WW-1:0] snap;
        build(n, directed);
        bp_hold = hold;
        start_frame(n);
        @(negedge clk);
        #1;
        start_cyc = cyc - 1;
        if (start_busy) begin
            repeat (4) @(posedge clk);
            #2;
            i_start       = 1'b1;
            i_num_windows = CW'(n + 3);
            @(posedge clk);
            #2;
            i_start = 1'b0;
        end
        if (hold > 0) begin
            t = 0;
            while (!o_win_valid && t < 400) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("bp_valid_seen", o_win_valid, 1'b1);
            snap = o_window;
            viol = 0;
            repeat (19) begin
                @(negedge clk);
                #1;
                if (!o_win_valid || o_window !== snap || o_mem_ren || o_inc_raddr) viol++;
            end
            check("bp_hold_stable", viol, 0);
        end
        t = 0;
        while (done_cnt == 0 && t < n * 9 * 14 + 80) begin
            @(negedge clk);
            #1;
            t++;
        end
        repeat (2) @(negedge clk);
        #1;
        check("frame_done_count", done_cnt, 1);
        check("mem_read_count", ren_cnt, 9 * n);
        check("inc_count", inc_cnt, (n > 0) ? 9 * n - 1 : 0);
        check("handshake_count", hs_cnt, n);
        check("busy_after_frame", o_busy, 1'b0);
        check("windows_left", exp_win.size(), 0);
        if (n > 0) check("done_after_last_accept", done_cyc, last_hs_cyc + 1);
        else check("zero_done_latency", (done_cyc - start_cyc >= 1 && done_cyc - start_cyc <= 2), 1);
    endtask

    task automatic reset_mid();
        int t;
        build(2, 1'b0);
        force_lat = 3;
        acc_always = 1'b1;
        start_frame(2);
        t = 0;
        while (ren_cnt < 3 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("rst_mid_reached", ren_cnt, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ctrl", {o_inc_raddr, o_mem_ren, o_mem_addr, o_win_valid, o_busy, o_frame_done}, '0);
        check("rst_mid_window", o_window, '0);
        exp_addr.delete();
        exp_win.delete();
        force_lat = 0;
        repeat (6) @(negedge clk);
        check("rst_mid_late_rvalid", {o_busy, o_mem_ren, o_win_valid}, '0);
    endtask

    initial begin : main
        rst = 1'b1; i_start = 1'b0; i_num_windows = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {o_inc_raddr, o_mem_ren, o_mem_addr, o_win_valid, o_busy, o_frame_done}, '0);
        check("reset_window", o_window, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        acc_always = 1'b1;
        run_frame(1, 1'b1, 1'b0, 0);
        check("directed_first_addr", first_addr, 32'h100);
        check("directed_window", last_win, 72'h18_17_16_15_14_13_12_11_10);

        run_frame(1, 1'b0, 1'b0, 20);
        run_frame(3, 1'b0, 1'b0, 0);
        run_frame(0, 1'b0, 1'b0, 0);
        run_frame(2, 1'b0, 1'b1, 0);

        reset_mid();
        run_frame(1, 1'b0, 1'b0, 0);

        acc_always = 1'b0;
        repeat (4) run_frame(int'($urandom_range(1, 4)), 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
